// File: rtl/ttl_pkg.sv
// rtl/ttl_pkg.sv - shared constants and preset/clear override mapping for the TTL flip-flop bank
package ttl_pkg;

  localparam logic EDGE_RISE  = 1'b1;
  localparam logic EDGE_FALL  = 1'b0;
  localparam int   FILT_CNT_W = 4;

  typedef struct packed {
    logic q;
    logic q_n;
  } ff_out_t;

  // Asynchronous-style override is in force whenever either control is low.
  function automatic logic ovr_active(input logic pre_n, input logic clr_n);
    return ~(pre_n & clr_n);
  endfunction

  // Both low drives both outputs high, as the real 7474 does.
  function automatic ff_out_t ovr_map(input logic pre_n, input logic clr_n);
    ff_out_t r;
    r.q   = ~pre_n;
    r.q_n = ~clr_n;
    return r;
  endfunction

endpackage

// File: rtl/ttl_dff_bank_if.sv
// rtl/ttl_dff_bank_if.sv - logic clock, data, preset/clear and output bundle of the flip-flop bank
interface ttl_dff_bank_if #(
  parameter int WIDTH = 4
);

  logic             clk;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] pre_n;
  logic [WIDTH-1:0] clr_n;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             edge_seen;

  modport master (
    output clk, d, pre_n, clr_n,
    input  q, q_n, edge_seen
  );

  modport slave (
    input  clk, d, pre_n, clr_n,
    output q, q_n, edge_seen
  );

endinterface

// File: rtl/ttl_clk_filter.sv
// rtl/ttl_clk_filter.sv - optional clk stability filter (CLK_FILTER_EN), matched d delay, edge detector
module ttl_clk_filter
  import ttl_pkg::*;
#(
  parameter int   WIDTH       = 4,
  parameter logic CLK_EDGE    = EDGE_RISE,
  parameter int   FILT_CYCLES = 2
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic             edge_det,
  output logic [WIDTH-1:0] s_d
);

  localparam logic INACTIVE = (CLK_EDGE == EDGE_RISE) ? EDGE_FALL : EDGE_RISE;

  logic             clk_f;
  logic [WIDTH-1:0] d_f;
  logic             s_clk;

`ifdef CLK_FILTER_EN
  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_CYCLES - 1);

  logic [FILT_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]      d_dly [FILT_CYCLES];

  always_ff @(posedge mclk) begin
    if (reset) begin
      clk_f <= CLK_EDGE;
      cnt   <= '0;
      for (int i = 0; i < FILT_CYCLES; i++) begin
        d_dly[i] <= '0;
      end
    end else begin
      if (clk != clk_f) begin
        if (cnt == CNT_LAST) begin
          clk_f <= clk;
          cnt   <= '0;
        end else begin
          cnt <= cnt + FILT_CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      // d travels through as many stages as clk needs to be accepted
      d_dly[0] <= d;
      for (int i = 1; i < FILT_CYCLES; i++) begin
        d_dly[i] <= d_dly[i-1];
      end
    end
  end

  assign d_f = d_dly[FILT_CYCLES-1];
`else
  assign clk_f = clk;
  assign d_f   = d;
`endif

  // s_clk starts at the active level so a clk already active at reset release is not an edge.
  always_ff @(posedge mclk) begin
    if (reset) begin
      s_clk <= CLK_EDGE;
      s_d   <= '0;
    end else begin
      s_clk <= clk_f;
      s_d   <= d_f;
    end
  end

  assign edge_det = (clk_f == CLK_EDGE) && (s_clk == INACTIVE);

endmodule

// File: rtl/ttl_dff_bank.sv
// rtl/ttl_dff_bank.sv - bank of TTL-style D flip-flops on mclk; build with CLK_FILTER_EN for clk filtering
module ttl_dff_bank
  import ttl_pkg::*;
#(
  parameter int   WIDTH       = 4,
  parameter logic CLK_EDGE    = EDGE_RISE,
  parameter int   FILT_CYCLES = 2
) (
  input  logic           mclk,
  input  logic           reset,
  ttl_dff_bank_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 32 || FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_param_check
    $error("ttl_dff_bank: parameter out of range");
  end

  logic             edge_det;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] ovr_en;
  logic [WIDTH-1:0] ovr_q;
  logic [WIDTH-1:0] ovr_qn;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qn_r;
  logic             edge_r;

  ttl_clk_filter #(
    .WIDTH       (WIDTH),
    .CLK_EDGE    (CLK_EDGE),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_clk_filter (
    .mclk     (mclk),
    .reset    (reset),
    .clk      (bus.clk),
    .d        (bus.d),
    .edge_det (edge_det),
    .s_d      (s_d)
  );

  always_comb begin
    ovr_en = '0;
    ovr_q  = '0;
    ovr_qn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ovr_en[i]              = ovr_active(bus.pre_n[i], bus.clr_n[i]);
      {ovr_q[i], ovr_qn[i]}  = ovr_map(bus.pre_n[i], bus.clr_n[i]);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      q_r    <= '0;
      qn_r   <= '1;
      edge_r <= 1'b0;
    end else begin
      edge_r <= edge_det;
      for (int i = 0; i < WIDTH; i++) begin
        if (ovr_en[i]) begin
          q_r[i]  <= ovr_q[i];
          qn_r[i] <= ovr_qn[i];
        end else if (edge_det) begin
          q_r[i]  <= s_d[i];
          qn_r[i] <= ~s_d[i];
        end else begin
          // re-derive q_n so a released double override becomes complementary again
          qn_r[i] <= ~q_r[i];
        end
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.q_n       = qn_r;
  assign bus.edge_seen = edge_r;

endmodule

// File: tb/tb_ttl_dff_bank.sv
// tb/tb_ttl_dff_bank.sv - directed scoreboard bench for ttl_dff_bank, rising and falling edge instances
module tb_ttl_dff_bank;
  import ttl_pkg::*;

`ifdef CLK_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic mclk = 1'b0;
  logic reset;

  always #5 mclk = ~mclk;

  ttl_dff_bank_if #(.WIDTH(4)) br ();
  ttl_dff_bank_if #(.WIDTH(4)) bf ();

  ttl_dff_bank #(.WIDTH(4), .CLK_EDGE(EDGE_RISE), .FILT_CYCLES(2)) dut_r (
    .mclk  (mclk),
    .reset (reset),
    .bus   (br)
  );

  ttl_dff_bank #(.WIDTH(4), .CLK_EDGE(EDGE_FALL), .FILT_CYCLES(2)) dut_f (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bf)
  );

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic [3:0] qn;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push(input string tag, input logic [3:0] q, input logic [3:0] qn, input logic e);
    exp_t x;
    x.tag = tag;
    x.q   = q;
    x.qn  = qn;
    x.e   = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic settle();
    repeat (LAT) tick();
  endtask

  task automatic chk(input bit fall);
    exp_t       x;
    logic [3:0] oq, oqn;
    logic       oe;
    oq  = fall ? bf.q : br.q;
    oqn = fall ? bf.q_n : br.q_n;
    oe  = fall ? bf.edge_seen : br.edge_seen;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL sb_empty: queue size=%0d required nonzero", sb.size());
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      assert ({oq, oqn, oe} === {x.q, x.qn, x.e}) else begin
        miscompares++;
        $error("FAIL %s: q=%h q_n=%h edge_seen=%b, required q=%h q_n=%h edge_seen=%b",
               x.tag, oq, oqn, oe, x.q, x.qn, x.e);
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] q, input logic [3:0] qn,
                      input logic e, input bit fall);
    push(tag, q, qn, e);
    tick();
    chk(fall);
  endtask

  initial begin
    reset    = 1'b1;
    br.clk   = 1'b1;
    br.d     = 4'h0;
    br.pre_n = 4'hF;
    br.clr_n = 4'hF;
    bf.clk   = 1'b0;
    bf.d     = 4'h0;
    bf.pre_n = 4'hF;
    bf.clr_n = 4'hF;

    // reset with clk high, then release with clk still high
    step("rst_a", 4'h0, 4'hF, 1'b0, 0);
    step("rst_b", 4'h0, 4'hF, 1'b0, 0);
    reset = 1'b0;
    step("rel_hold", 4'h0, 4'hF, 1'b0, 0);
    step("rel_hold2", 4'h0, 4'hF, 1'b0, 0);

    // basic capture
    br.d = 4'hA; br.clk = 1'b0; settle();
    step("t2_low", 4'h0, 4'hF, 1'b0, 0);
    br.clk = 1'b1; settle();
    step("t2_cap", 4'hA, 4'h5, 1'b1, 0);
    step("t2_pulse_end", 4'hA, 4'h5, 1'b0, 0);

    // setup-time model: d changing with clk captures the old d
    br.d = 4'h3; br.clk = 1'b0; settle();
    step("t3_low", 4'hA, 4'h5, 1'b0, 0);
    br.d = 4'hC; br.clk = 1'b1; settle();
    step("t3_old_d", 4'h3, 4'hC, 1'b1, 0);
    br.clk = 1'b0; settle();
    step("t3_low2", 4'h3, 4'hC, 1'b0, 0);
    br.clk = 1'b1; settle();
    step("t3_new_d", 4'hC, 4'h3, 1'b1, 0);

    // preset/clear overrides
    br.pre_n = 4'hE; br.clr_n = 4'hE;
    step("t4_both", 4'hD, 4'h3, 1'b0, 0);
    br.pre_n = 4'hF; br.clr_n = 4'hF;
    step("t4_release", 4'hD, 4'h2, 1'b0, 0);
    br.pre_n = 4'h7; br.clr_n = 4'hB;
    step("t4_pre_clr", 4'h9, 4'h6, 1'b0, 0);
    br.pre_n = 4'hF; br.clr_n = 4'hF;
    step("t4_rel2", 4'h9, 4'h6, 1'b0, 0);

    // edge while every bit is preset still strobes edge_seen
    br.d = 4'hC; br.clk = 1'b0; settle();
    step("ovr_low", 4'h9, 4'h6, 1'b0, 0);
    br.clk = 1'b1; settle();
    br.pre_n = 4'h0;
    step("ovr_edge", 4'hF, 4'h0, 1'b1, 0);
    br.pre_n = 4'hF;
    step("ovr_rel", 4'hF, 4'h0, 1'b0, 0);

`ifdef CLK_FILTER_EN
    br.d = 4'h5; br.clk = 1'b0; settle();
    step("t5_low", 4'hF, 4'h0, 1'b0, 0);
    br.clk = 1'b1;
    step("t5_glitch_hi", 4'hF, 4'h0, 1'b0, 0);
    br.clk = 1'b0;
    step("t5_glitch_lo", 4'hF, 4'h0, 1'b0, 0);
    step("t5_glitch_after", 4'hF, 4'h0, 1'b0, 0);
    step("t5_glitch_after2", 4'hF, 4'h0, 1'b0, 0);
    br.clk = 1'b1;
    step("t5_hold1", 4'hF, 4'h0, 1'b0, 0);
    step("t5_hold2", 4'hF, 4'h0, 1'b0, 0);
    step("t5_cap", 4'h5, 4'hA, 1'b1, 0);
    step("t5_after", 4'h5, 4'hA, 1'b0, 0);
`else
    br.d = 4'h5; br.clk = 1'b0;
    step("t5_low", 4'hF, 4'h0, 1'b0, 0);
    br.clk = 1'b1;
    step("t5_pulse", 4'h5, 4'hA, 1'b1, 0);
    br.clk = 1'b0;
    step("t5_after", 4'h5, 4'hA, 1'b0, 0);
    // clk toggling every cycle gives one edge per two cycles
    br.clk = 1'b1;
    step("tog_1", 4'h5, 4'hA, 1'b1, 0);
    br.clk = 1'b0;
    step("tog_0", 4'h5, 4'hA, 1'b0, 0);
    br.clk = 1'b1;
    step("tog_1b", 4'h5, 4'hA, 1'b1, 0);
`endif

    // reset coinciding with an edge and a preset
    br.d = 4'hF; br.clk = 1'b0; settle();
    step("t6_low", 4'h5, 4'hA, 1'b0, 0);
    br.clk = 1'b1; settle();
    reset = 1'b1; br.pre_n = 4'h0;
    step("t6_rst_edge", 4'h0, 4'hF, 1'b0, 0);
    reset = 1'b0; br.pre_n = 4'hF;
    step("t6_no_edge", 4'h0, 4'hF, 1'b0, 0);
    br.clk = 1'b0; settle();
    step("t6_low2", 4'h0, 4'hF, 1'b0, 0);
    br.clk = 1'b1; settle();
    step("t6_fresh", 4'hF, 4'h0, 1'b1, 0);

    // falling-edge instance
    bf.d = 4'h9; bf.clk = 1'b1; settle();
    step("f_rise", 4'h0, 4'hF, 1'b0, 1);
    bf.clk = 1'b0; settle();
    step("f_fall", 4'h9, 4'h6, 1'b1, 1);
    bf.d = 4'h4; bf.clk = 1'b1; settle();
    step("f_rise2", 4'h9, 4'h6, 1'b0, 1);
    bf.clk = 1'b0; settle();
    step("f_fall2", 4'h4, 4'hB, 1'b1, 1);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_leftover: queue size=%0d required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
